// File: rtl/sumres_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// FSM states and the operation encoding of the mode input.
package sumres_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/sumador_completo_1b.sv
// One-bit combinational full adder.
// It is the only arithmetic cell of the serial loop.
module sumador_completo_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sumador_restador_serie.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, with a start/busy/done handshake.
// Optional signed-overflow output ovf is enabled by defining SUMRES_OVERFLOW_EN.
module sumador_restador_serie
  import sumres_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SUMRES_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-2:0]   res_sh;
  logic [WIDTH-1:0]   res_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_cout;
  logic               load;
  logic               last;

  sumador_completo_1b u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign load     = start & ready;
  assign last     = (cnt == LAST);
  assign res_next = {fa_s, res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last ? DONE : SHIFT;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == SHIFT);
    done  = (state == DONE);
  end

  // Subtraction loads ~B with carry-in 1, so the loop always just adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      cout   <= 1'b0;
`ifdef SUMRES_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b ^ {WIDTH{mode}};
      carry <= mode;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= res_next[WIDTH-1:1];
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        s    <= res_next;
        cout <= fa_cout;
`ifdef SUMRES_OVERFLOW_EN
        ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Scoreboard bench for sumador_restador_serie: WIDTH=4 and WIDTH=8 instances.
// Define SUMRES_OVERFLOW_EN to also check the ovf output.
module tb_sumador_restador_serie;
  import sumres_pkg::*;

  localparam int W  = 4;
  localparam int W8 = 8;

  typedef struct {
    logic [7:0]  s;
    logic        cout;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, busy, done, cout;
  logic [W-1:0]  s;
  logic          start8 = 1'b0;
  logic          mode8 = 1'b0;
  logic [W8-1:0] a8 = '0;
  logic [W8-1:0] b8 = '0;
  logic          ready8, busy8, done8, cout8;
  logic [W8-1:0] s8;
`ifdef SUMRES_OVERFLOW_EN
  logic          ovf, ovf8;
`endif

  exp_t          q4[$];
  exp_t          q8[$];
  int            n_vec  = 0;
  int            n_fail = 0;
  int unsigned   cyc    = 0;
  logic [W-1:0]  last_s = '0;
  logic          last_c = 1'b0;

  sumador_restador_serie #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .s(s), .cout(cout)
`ifdef SUMRES_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  sumador_restador_serie #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef SUMRES_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for ready, issues one W=4 op and pushes its hand-computed result.
  task automatic apply_stimulus(input logic md, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic [W-1:0] es, input logic ec, input logic eo,
                                input bit hold);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check_output("ready_timeout", 32'(ready), 32'd1);
    mode  = md;
    a     = aa;
    b     = bb;
    start = 1'b1;
    e.s = 8'(es); e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + W;
    q4.push_back(e);
    @(negedge clk);
    start = hold;
    mode  = ~md;
    a     = ~aa;
    b     = ~bb;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((q4.size() != 0 || q8.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q4.size() != 0 || q8.size() != 0)
      check_output("drain_timeout", 32'(q4.size() + q8.size()), 32'd0);
  endtask

  // Monitor for the WIDTH=4 instance: reset values, results, latency and hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check_output("rst_s", 32'(s), 32'd0);
        check_output("rst_cout", 32'(cout), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_ready", 32'(ready), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
`ifdef SUMRES_OVERFLOW_EN
        check_output("rst_ovf", 32'(ovf), 32'd0);
`endif
        last_s = '0;
        last_c = 1'b0;
      end else if (done) begin
        if (q4.size() == 0) begin
          check_output("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q4.pop_front();
          check_output("sum", 32'(s), 32'(e.s));
          check_output("cout", 32'(cout), 32'(e.cout));
          check_output("latency", 32'(cyc), 32'(e.cyc));
`ifdef SUMRES_OVERFLOW_EN
          check_output("ovf", 32'(ovf), 32'(e.ovf));
`endif
          last_s = e.s[W-1:0];
          last_c = e.cout;
        end
      end else begin
        check_output("s_held", 32'(s), 32'(last_s));
        check_output("cout_held", 32'(cout), 32'(last_c));
      end
    end
  end

  // Monitor for the WIDTH=8 instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && done8) begin
        if (q8.size() == 0) begin
          check_output("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          e = q8.pop_front();
          check_output("sum8", 32'(s8), 32'(e.s));
          check_output("cout8", 32'(cout8), 32'(e.cout));
          check_output("latency8", 32'(cyc), 32'(e.cyc));
`ifdef SUMRES_OVERFLOW_EN
          check_output("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 3+1: check the handshake while the op is in flight.
    apply_stimulus(MODE_ADD, 4'd3, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      check_output("busy_shift", 32'(busy), 32'd1);
      check_output("ready_shift", 32'(ready), 32'd0);
      @(negedge clk);
    end
    check_output("busy_done", 32'(busy), 32'd0);
    check_output("ready_done", 32'(ready), 32'd1);

    apply_stimulus(MODE_SUB, 4'd1,  4'd1, 4'd0,  1'b1, 1'b0, 1'b0);
    apply_stimulus(MODE_SUB, 4'd1,  4'd2, 4'd15, 1'b0, 1'b0, 1'b0);
    apply_stimulus(MODE_ADD, 4'd15, 4'd1, 4'd0,  1'b1, 1'b0, 1'b0);
    apply_stimulus(MODE_ADD, 4'd7,  4'd1, 4'd8,  1'b0, 1'b1, 1'b0);
    // A start pulse with junk operands while shifting must be ignored.
    start = 1'b1; a = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    apply_stimulus(MODE_ADD, 4'd3,  4'd1, 4'd4,  1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high and operands scrambled during SHIFT.
    apply_stimulus(MODE_ADD, 4'd5, 4'd6, 4'd11, 1'b0, 1'b1, 1'b1);
    apply_stimulus(MODE_SUB, 4'd9, 4'd3, 4'd6,  1'b1, 1'b1, 1'b1);
    apply_stimulus(MODE_ADD, 4'd8, 4'd8, 4'd0,  1'b1, 1'b1, 1'b1);
    apply_stimulus(MODE_SUB, 4'd2, 4'd5, 4'd13, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Reset during the second SHIFT cycle: no result may follow.
    @(negedge clk);
    mode = MODE_ADD; a = 4'd5; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * W) @(negedge clk);

    // WIDTH=8 regression.
    mode8 = MODE_SUB; a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    e.s = 8'h7F; e.cout = 1'b1; e.ovf = 1'b1; e.cyc = cyc + 1 + W8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    repeat (W8 + 1) @(negedge clk);
    mode8 = MODE_ADD; a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    e.s = 8'h00; e.cout = 1'b1; e.ovf = 1'b0; e.cyc = cyc + 1 + W8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;

    wait_drain();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
